// File: rtl/cpu_pkg.sv
// Shared types for the CPU control path.
// Holds the datapath control enums, the decoded control bundle and the
// width constants used by cpu_control and its decoder.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 8;
    localparam int unsigned TCYCLE_W = 2;
    localparam logic [TCYCLE_W-1:0] TCYCLE_LAST = TCYCLE_W'(3);

    typedef enum logic {
        PcNextSame = 1'b0,
        PcNextInc  = 1'b1
    } pc_next_e;

    typedef enum logic [1:0] {
        RegSelA        = 2'd0,
        RegSelReg8Src  = 2'd1,
        RegSelReg8Dest = 2'd2
    } reg_sel_e;

    typedef enum logic {
        RegInputAlu = 1'b0,
        RegInputMem = 1'b1
    } reg_input_e;

    typedef enum logic {
        AluOpCopyA = 1'b0,
        AluOpIncA  = 1'b1
    } alu_op_e;

    typedef enum logic {
        AluSelAReg1 = 1'b0
    } alu_sel_a_e;

    typedef enum logic {
        AluSelBReg2 = 1'b0
    } alu_sel_b_e;

    // Control bundle driven to the datapath for one M-cycle.
    typedef struct packed {
        pc_next_e   pc_next;
        logic       inst_load;
        reg_sel_e   reg_read1_sel;
        reg_sel_e   reg_read2_sel;
        reg_sel_e   reg_write_sel;
        logic       reg_write_enable;
        reg_input_e reg_write_input;
        alu_op_e    alu_op;
        alu_sel_a_e alu_sel_a;
        alu_sel_b_e alu_sel_b;
        logic       mem_enable;
        logic       mem_write;
    } ctrl_t;

    // Idle bundle: no bus access, PC held, no register write.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c.pc_next          = PcNextSame;
        c.inst_load        = 1'b0;
        c.reg_read1_sel    = RegSelA;
        c.reg_read2_sel    = RegSelA;
        c.reg_write_sel    = RegSelA;
        c.reg_write_enable = 1'b0;
        c.reg_write_input  = RegInputAlu;
        c.alu_op           = AluOpCopyA;
        c.alu_sel_a        = AluSelAReg1;
        c.alu_sel_b        = AluSelBReg2;
        c.mem_enable       = 1'b0;
        c.mem_write        = 1'b0;
        return c;
    endfunction

    // Opcode fetch overlaid on the idle bundle.
    function automatic ctrl_t ctrl_fetch();
        ctrl_t c;
        c           = ctrl_idle();
        c.mem_enable = 1'b1;
        c.inst_load  = 1'b1;
        c.pc_next    = PcNextInc;
        return c;
    endfunction

endpackage

// File: rtl/cpu_control_decode.sv
// Combinational instruction decoder.
// Ports:
//   opcode  in   current opcode
//   step    in   M-cycle index within the instruction
//   ctrl    out  control bundle for this M-cycle
//   last    out  this M-cycle is the fetch that ends the instruction
//   illegal out  opcode is not supported (decoded as NOP)
module cpu_control_decode
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                step,
    output ctrl_t               ctrl,
    output logic                last,
    output logic                illegal
);

    logic [2:0] dst;
    logic [2:0] src;

    assign dst = opcode[5:3];
    assign src = opcode[2:0];

    // Register code 6 is the (HL) memory operand, which is not supported.
    always_comb begin
        ctrl    = ctrl_fetch();
        last    = 1'b1;
        illegal = 1'b0;
        if (step) begin
            // Only LD r,n reaches step 1: plain fetch.
            ctrl = ctrl_fetch();
        end else if (opcode == OPCODE_W'(8'h00)) begin
            ctrl = ctrl_fetch();
        end else if (opcode[7:6] == 2'b01 && dst != 3'd6 && src != 3'd6) begin
            // LD r,r'
            ctrl.reg_read1_sel    = RegSelReg8Src;
            ctrl.alu_op           = AluOpCopyA;
            ctrl.reg_write_sel    = RegSelReg8Dest;
            ctrl.reg_write_input  = RegInputAlu;
            ctrl.reg_write_enable = 1'b1;
        end else if (opcode[7:6] == 2'b00 && src == 3'd4 && dst != 3'd6) begin
            // INC r
            ctrl.reg_read1_sel    = RegSelReg8Dest;
            ctrl.alu_op           = AluOpIncA;
            ctrl.reg_write_sel    = RegSelReg8Dest;
            ctrl.reg_write_input  = RegInputAlu;
            ctrl.reg_write_enable = 1'b1;
        end else if (opcode[7:6] == 2'b00 && src == 3'd6 && dst != 3'd6) begin
            // LD r,n step 0: read the immediate straight into the register
            ctrl                  = ctrl_idle();
            ctrl.mem_enable       = 1'b1;
            ctrl.pc_next          = PcNextInc;
            ctrl.reg_write_sel    = RegSelReg8Dest;
            ctrl.reg_write_input  = RegInputMem;
            ctrl.reg_write_enable = 1'b1;
            last                  = 1'b0;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_control.sv
// CPU control unit: holds the opcode/step state and drives datapath controls.
// Outputs depend only on registered state, so they are stable for a whole
// M-cycle; state advances on the clk edge where t_cycle == 3.
// Build option: define CPU_CONTROL_ILLEGAL_TRAP_EN to lock the core on an
// unsupported opcode (until reset); otherwise such opcodes run as NOP.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   t_cycle              T-cycle index within the M-cycle
//   mem_data_in          bus read data (opcode on a fetch)
//   pc_next .. mem_write datapath control outputs
module cpu_control
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [TCYCLE_W-1:0] t_cycle,
    input  logic [OPCODE_W-1:0] mem_data_in,
    output pc_next_e            pc_next,
    output logic                inst_load,
    output reg_sel_e            reg_read1_sel,
    output reg_sel_e            reg_read2_sel,
    output reg_sel_e            reg_write_sel,
    output logic                reg_write_enable,
    output reg_input_e          reg_write_input,
    output alu_op_e             alu_op,
    output alu_sel_a_e          alu_sel_a,
    output alu_sel_b_e          alu_sel_b,
    output logic                mem_enable,
    output logic                mem_write
);

    logic [OPCODE_W-1:0] opcode;
    logic                step;
    ctrl_t               dec_ctrl;
    ctrl_t               ctrl;
    logic                dec_last;
    logic                dec_illegal;
    logic                end_of_mcycle;
    logic                hold_c;

    cpu_control_decode u_decode (
        .opcode  (opcode),
        .step    (step),
        .ctrl    (dec_ctrl),
        .last    (dec_last),
        .illegal (dec_illegal)
    );

    assign end_of_mcycle = (t_cycle == TCYCLE_LAST);

`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
    logic lock;

    // Unsupported opcode freezes the core; only reset releases it.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock <= 1'b0;
        end else if (end_of_mcycle && dec_illegal) begin
            lock <= 1'b1;
        end
    end

    assign hold_c = lock | dec_illegal;

    always_comb begin
        ctrl = dec_ctrl;
        if (hold_c) begin
            ctrl = ctrl_idle();
        end
    end
`else
    logic unused_illegal;

    assign unused_illegal = dec_illegal;
    assign hold_c         = 1'b0;

    always_comb begin
        ctrl = dec_ctrl;
    end
`endif

    // Opcode/step update; the executing instruction's write and the next
    // opcode load share this edge, so the write decodes from the old opcode.
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode <= OPCODE_W'(8'h00);
            step   <= 1'b0;
        end else if (end_of_mcycle && !hold_c) begin
            if (dec_last) begin
                opcode <= mem_data_in;
                step   <= 1'b0;
            end else begin
                step   <= 1'b1;
            end
        end
    end

    assign pc_next          = ctrl.pc_next;
    assign inst_load        = ctrl.inst_load;
    assign reg_read1_sel    = ctrl.reg_read1_sel;
    assign reg_read2_sel    = ctrl.reg_read2_sel;
    assign reg_write_sel    = ctrl.reg_write_sel;
    assign reg_write_enable = ctrl.reg_write_enable;
    assign reg_write_input  = ctrl.reg_write_input;
    assign alu_op           = ctrl.alu_op;
    assign alu_sel_a        = ctrl.alu_sel_a;
    assign alu_sel_b        = ctrl.alu_sel_b;
    assign mem_enable       = ctrl.mem_enable;
    assign mem_write        = ctrl.mem_write;

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: a table of M-cycles (bus data plus
// expected controls) followed by hand-written reset and lock sequences.
module tb_cpu_control;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] t_cycle = 2'd0;
    logic [7:0] mem_data_in = 8'h00;

    pc_next_e   pc_next;
    logic       inst_load;
    reg_sel_e   reg_read1_sel;
    reg_sel_e   reg_read2_sel;
    reg_sel_e   reg_write_sel;
    logic       reg_write_enable;
    reg_input_e reg_write_input;
    alu_op_e    alu_op;
    alu_sel_a_e alu_sel_a;
    alu_sel_b_e alu_sel_b;
    logic       mem_enable;
    logic       mem_write;

    cpu_control dut (
        .clk              (clk),
        .reset            (reset),
        .t_cycle          (t_cycle),
        .mem_data_in      (mem_data_in),
        .pc_next          (pc_next),
        .inst_load        (inst_load),
        .reg_read1_sel    (reg_read1_sel),
        .reg_read2_sel    (reg_read2_sel),
        .reg_write_sel    (reg_write_sel),
        .reg_write_enable (reg_write_enable),
        .reg_write_input  (reg_write_input),
        .alu_op           (alu_op),
        .alu_sel_a        (alu_sel_a),
        .alu_sel_b        (alu_sel_b),
        .mem_enable       (mem_enable),
        .mem_write        (mem_write)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_enable;
        logic       mem_write;
        logic       inst_load;
        logic       pc_next;
        logic [1:0] rd1;
        logic [1:0] rd2;
        logic [1:0] wr;
        logic       rwe;
        logic       rin;
        logic       alu;
        logic       sela;
        logic       selb;
    } obs_t;

    typedef struct {
        logic [7:0] data;
        obs_t       exp;
        string      name;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    obs_t sb_q[$];

    function automatic obs_t mk(input logic mem, input logic inst, input logic pc,
                                input logic [1:0] rd1, input logic [1:0] wr,
                                input logic rwe, input logic rin, input logic alu);
        obs_t o;
        o            = '0;
        o.mem_enable = mem;
        o.inst_load  = inst;
        o.pc_next    = pc;
        o.rd1        = rd1;
        o.wr         = wr;
        o.rwe        = rwe;
        o.rin        = rin;
        o.alu        = alu;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.mem_enable = mem_enable;
        o.mem_write  = mem_write;
        o.inst_load  = inst_load;
        o.pc_next    = pc_next;
        o.rd1        = reg_read1_sel;
        o.rd2        = reg_read2_sel;
        o.wr         = reg_write_sel;
        o.rwe        = reg_write_enable;
        o.rin        = reg_write_input;
        o.alu        = alu_op;
        o.sela       = alu_sel_a;
        o.selb       = alu_sel_b;
        return o;
    endfunction

    // Encoded expectations: sel codes A=0, Src=1, Dest=2.
    obs_t FETCH, INC_R, LD_RR, LD_N0, LOCKED, ILL;

    task automatic check_obs(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // One full M-cycle; expected controls go through the scoreboard queue.
    task automatic run_mcycle(input logic [7:0] data, input obs_t exp, input string name);
        obs_t e;
        e = '0;
        sb_q.push_back(exp);
        for (int t = 0; t < 4; t++) begin
            t_cycle     = 2'(t);
            mem_data_in = data;
            @(negedge clk);
            if (t == 0) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s scoreboard empty", name);
                end else begin
                    e = sb_q.pop_front();
                end
            end
            check_obs($sformatf("%s.t%0d", name, t), e);
            @(posedge clk);
            #1;
        end
    endtask

    // Reset on an edge where t_cycle is not 3.
    task automatic do_reset();
        t_cycle = 2'd1;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
    endtask

    vec_t vecs[17];

    initial begin
        FETCH  = mk(1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        INC_R  = mk(1'b1, 1'b1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1);
        LD_RR  = mk(1'b1, 1'b1, 1'b1, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
        LD_N0  = mk(1'b1, 1'b0, 1'b1, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0);
        LOCKED = '0;
`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
        ILL = LOCKED;
`else
        ILL = FETCH;
`endif

        vecs[0]  = '{8'h00, FETCH, "nop_after_reset"};
        vecs[1]  = '{8'h3C, FETCH, "fetch_inc_a"};
        vecs[2]  = '{8'h78, INC_R, "inc_a"};
        vecs[3]  = '{8'h06, LD_RR, "ld_a_b"};
        vecs[4]  = '{8'h55, LD_N0, "ld_b_n_s0"};
        vecs[5]  = '{8'h7D, FETCH, "ld_b_n_s1"};
        vecs[6]  = '{8'h04, LD_RR, "ld_a_l"};
        vecs[7]  = '{8'h3E, INC_R, "inc_b"};
        vecs[8]  = '{8'hA5, LD_N0, "ld_a_n_s0"};
        vecs[9]  = '{8'h2C, FETCH, "ld_a_n_s1"};
        vecs[10] = '{8'h00, INC_R, "inc_l"};
        vecs[11] = '{8'h46, FETCH, "nop_fetch_ld_hl"};
        vecs[12] = '{8'h34, ILL,   "ld_b_hl"};
        vecs[13] = '{8'h36, ILL,   "inc_hl"};
        vecs[14] = '{8'h76, ILL,   "ld_hl_n"};
        vecs[15] = '{8'h00, ILL,   "halt"};
        vecs[16] = '{8'h00, ILL,   "after_halt"};

        // Reset state: opcode 0 decodes as a fetch.
        reset   = 1'b1;
        t_cycle = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_obs("reset_state", FETCH);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_mcycle(vecs[i].data, vecs[i].exp, vecs[i].name);
        end

        // HALT: lock (when enabled) persists until reset, then fetch resumes.
        do_reset();
        run_mcycle(8'h76, FETCH, "halt_fetch");
        run_mcycle(8'h00, ILL,   "halt_exec");
        run_mcycle(8'h3C, ILL,   "halt_hold");
        do_reset();
        run_mcycle(8'h00, FETCH, "unlock_fetch");

        // Reset in step 0 of LD B,n aborts the instruction.
        run_mcycle(8'h06, FETCH, "pre_ld_n");
        t_cycle     = 2'd0;
        mem_data_in = 8'h11;
        @(negedge clk);
        check_obs("ld_n_s0_before_reset", LD_N0);
        @(posedge clk);
        #1;
        do_reset();
        run_mcycle(8'h78, FETCH, "s0_reset_nop");
        run_mcycle(8'h00, LD_RR, "s0_reset_next");

        // Reset in step 1 of LD B,n: next M-cycle is the NOP fetch.
        run_mcycle(8'h06, FETCH, "pre_ld_n2");
        run_mcycle(8'h22, LD_N0, "ld_n2_s0");
        t_cycle     = 2'd0;
        mem_data_in = 8'h3C;
        @(negedge clk);
        check_obs("ld_n2_s1_before_reset", FETCH);
        @(posedge clk);
        #1;
        do_reset();
        run_mcycle(8'h3C, FETCH, "s1_reset_nop");
        run_mcycle(8'h00, INC_R, "s1_reset_next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 No parameters.
REQ-002 clk  input  1  system clock, 4 MHz nominal.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-004 t_cycle  input  2  T-cycle index within the current M-cycle, 0..3.
REQ-005 mem_data_in  input  8  system bus read data; carries the opcode at t_cycle==3 of a fetch.
REQ-006 pc_next  output  pc_next_e  PC update at end of M-cycle: PcNextSame=0, PcNextInc=1.
REQ-007 inst_load  output  1  datapath latches mem_data_in into its instruction register at t_cycle==3.
REQ-008 reg_read1_sel, reg_read2_sel, reg_write_sel  output  reg_sel_e  register selects: RegSelA=0, RegSelReg8Src=1 (bits 2:0), RegSelReg8Dest=2 (bits 5:3).
REQ-009 reg_write_enable  output  1  register write at t_cycle==3.
REQ-010 reg_write_input  output  reg_input_e  RegInputAlu=0, RegInputMem=1.
REQ-011 alu_op  output  alu_op_e  AluOpCopyA=0, AluOpIncA=1.
REQ-012 alu_sel_a / alu_sel_b  output  1 each  AluSelAReg1=0 / AluSelBReg2=0; both outputs are always 0.
REQ-013 mem_enable  output  1  bus access this M-cycle; mem_write  output  1  always 0.

Function
REQ-014 State:
- 8-bit opcode register (own copy).
- 1-bit step counter.
- State updates only on clk edges where t_cycle==3.
REQ-015 All outputs are combinational functions of (opcode, step, lock) only, so they are stable across all four T-cycles of an M-cycle.
REQ-016 Default outputs (unless overridden below):
- pc_next=Same, inst_load=0, mem_enable=0, reg_write_enable=0.
- all selects RegSelA, RegInputAlu, AluOpCopyA.
REQ-017 Fetch cycle (last M-cycle of every instruction):
- Outputs: mem_enable=1, inst_load=1, pc_next=Inc.
- At t_cycle==3: opcode<=mem_data_in, step<=0.
REQ-018 NOP 0x00: one M-cycle; fetch only.
REQ-019 LD r,r' (0x40-0x7F, excluding any opcode with bits 5:3==6 or bits 2:0==6): one M-cycle.
- Fetch plus reg_read1_sel=Src, AluOpCopyA.
- reg_write_sel=Dest, RegInputAlu, reg_write_enable=1.
REQ-020 INC r (00rrr100, rrr!=6): one M-cycle.
- Fetch plus reg_read1_sel=Dest, AluOpIncA.
- reg_write_sel=Dest, RegInputAlu, reg_write_enable=1.
REQ-021 LD r,n (00rrr110, rrr!=6): two M-cycles.
- Step 0: mem_enable=1, pc_next=Inc, inst_load=0, reg_write_sel=Dest, RegInputMem, reg_write_enable=1; step<=1.
- Step 1: plain fetch.
REQ-022 All other opcodes are unsupported, including HALT 0x76 and every (HL) form; their handling is set by REQ-026.
REQ-023 The write of the executing instruction and the next-opcode load happen on the same edge; the register write uses the old opcode.

Reset
REQ-024 reset at a clk edge sets opcode=0x00, step=0 and lock=0, regardless of t_cycle, including mid-instruction.
REQ-025 After reset, the first M-cycle executes NOP, which fetches from PC 0.

Configuration
REQ-026 Macro CPU_CONTROL_ILLEGAL_TRAP_EN controls unsupported opcodes.
- Defined: an unsupported opcode sets lock=1. While locked, all outputs take defaults: mem_enable=0, inst_load=0, pc_next=Same. Lock persists until reset.
- Undefined: unsupported opcodes execute as NOP and the lock logic is absent.

Structure
REQ-027 Package cpu_pkg holds pc_next_e, reg_sel_e, reg_input_e, alu_op_e, alu_sel_a_e and alu_sel_b_e with the encodings above. Both cpu and cpu_control import cpu_pkg.
REQ-028 Sub-module cpu_control_decode: purely combinational, maps (opcode, step) to the output bundle plus a "last" flag and an "illegal" flag. cpu_control keeps the sequential state.

Verification
REQ-029 Reset, mem_data_in=0x00 constantly -> every M-cycle: mem_enable=1, inst_load=1, pc_next=Inc, reg_write_enable=0.
REQ-030 Opcode 0x3C (INC A) fetched -> next M-cycle: read1=Dest, alu_op=IncA, write_sel=Dest, reg_write_enable=1, RegInputAlu, inst_load=1.
REQ-031 Opcode 0x78 (LD A,B) -> one M-cycle: read1=Src, CopyA, write_sel=Dest, reg_write_enable=1, inst_load=1.
REQ-032 Opcode 0x06 (LD B,n) -> M1: RegInputMem, reg_write_enable=1, inst_load=0, pc_next=Inc; M2: inst_load=1, reg_write_enable=0.
REQ-033 Opcode 0x76 -> without macro, behaves as NOP. With macro: following M-cycles have mem_enable=0, pc_next=Same and inst_load=0; reset restores fetching.
REQ-034 reset asserted during step 1 of 0x06 -> next M-cycle shows NOP fetch outputs.
